avalon_mm_arbiter: RTL and testbench



---
 rtl/avalon_mm_arbiter_pkg.sv | 5 +
 rtl/avalon_mm_arbiter_fifo.sv | 35 +++
 rtl/avalon_mm_arbiter.sv | 102 ++++++++++
 tb/tb_avalon_mm_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/avalon_mm_arbiter_pkg.sv
// avalon_mm_arbiter_pkg: shared source and FSM state types for the two-host Avalon-MM arbiter.
package AvalonArbPkg;
  typedef enum logic {SRC_DATA, SRC_INSTR} source_t;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
endpackage

// File: rtl/avalon_mm_arbiter_fifo.sv
// arb_pending_fifo: in-order record of which host issued each outstanding pipelined read.
module arb_pending_fifo
  import AvalonArbPkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  source_t din,
  output source_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(MAX_PENDING);
  source_t       mem_q [MAX_PENDING];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din;
  assign head  = mem_q[rd_q];
  assign full  = cnt_q == (AW+1)'(MAX_PENDING);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/avalon_mm_arbiter.sv
// avalon_mm_arbiter: merges data and instruction hosts onto one agent port with zero added latency.
// Define AVALON_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise data has fixed priority.
module avalon_mm_arbiter
  import AvalonArbPkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_address,
  input  logic [3:0]  d_byteenable,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_host_to_agent,
  output logic        d_waitrequest,
  output logic [31:0] d_agent_to_host,
  output logic        d_readdatavalid,
  input  logic [31:0] i_address,
  input  logic [3:0]  i_byteenable,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_agent_to_host,
  output logic        i_readdatavalid,
  output logic [31:0] a_address,
  output logic [3:0]  a_byteenable,
  output logic        a_read,
  output logic        a_write,
  output logic [31:0] a_host_to_agent,
  input  logic        a_waitrequest,
  input  logic [31:0] a_agent_to_host,
  input  logic        a_readdatavalid
);
  arb_state_t  state_q, state_d;
  source_t     owner_q, owner_d, sel, head;
  logic        rd_block, d_ok, i_ok, gnt, accept, push, pop, fifo_full, fifo_empty, tie_instr, sel_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  // A same-cycle return frees a slot, so a full FIFO only blocks reads when nothing pops.
  assign rd_block = fifo_full & ~a_readdatavalid;
  assign d_ok     = d_write | (d_read & ~rd_block);
  assign i_ok     = i_read & ~rd_block;
`ifdef AVALON_ARB_ROUND_ROBIN_EN
  source_t last_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_q <= SRC_INSTR;
    else if (accept) last_q <= sel;
  assign tie_instr = last_q == SRC_DATA;
`else
  assign tie_instr = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    sel = (state_q == ARB_LOCKED) ? owner_q : (d_ok & ~(i_ok & tie_instr)) ? SRC_DATA : SRC_INSTR;
    gnt = rst & ((state_q == ARB_LOCKED) | d_ok | i_ok);
    if (state_q == ARB_IDLE && gnt && a_waitrequest) begin
      state_d = ARB_LOCKED;
      owner_d = sel;
    end else if (state_q == ARB_LOCKED && !a_waitrequest) state_d = ARB_IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ARB_IDLE;
      owner_q <= SRC_DATA;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (gnt) begin
        addr_q  <= a_address;
        be_q    <= a_byteenable;
        wdata_q <= a_host_to_agent;
      end
    end
  assign sel_d           = sel == SRC_DATA;
  assign a_read          = gnt & (sel_d ? d_read : i_read);
  assign a_write         = gnt & sel_d & d_write;
  assign a_address       = gnt ? (sel_d ? d_address : i_address) : addr_q;
  assign a_byteenable    = gnt ? (sel_d ? d_byteenable : i_byteenable) : be_q;
  assign a_host_to_agent = (gnt & sel_d) ? d_host_to_agent : wdata_q;
  assign accept = gnt & ~a_waitrequest;
  assign push   = accept & a_read;
  assign pop    = a_readdatavalid & ~fifo_empty;
  assign d_waitrequest = ~rst | (d_read | d_write) & ((gnt & sel_d) ? a_waitrequest : 1'b1);
  assign i_waitrequest = ~rst | i_read & ((gnt & ~sel_d) ? a_waitrequest : 1'b1);
  assign d_readdatavalid = pop & (head == SRC_DATA);
  assign i_readdatavalid = pop & (head == SRC_INSTR);
  assign d_agent_to_host = d_readdatavalid ? a_agent_to_host : '0;
  assign i_agent_to_host = i_readdatavalid ? a_agent_to_host : '0;
  arb_pending_fifo #(.MAX_PENDING(MAX_PENDING)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (sel),
    .head (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// tb_avalon_mm_arbiter: directed stimulus with an expected-command and expected-return scoreboard.
module tb_avalon_mm_arbiter;
  logic clk = 0, rst;
  logic [31:0] d_address, d_host_to_agent, d_agent_to_host, i_address, i_agent_to_host;
  logic [31:0] a_address, a_host_to_agent, a_agent_to_host;
  logic [3:0]  d_byteenable, i_byteenable, a_byteenable;
  logic d_read, d_write, d_waitrequest, d_readdatavalid, i_read, i_waitrequest, i_readdatavalid;
  logic a_read, a_write, a_waitrequest, a_readdatavalid;
  int checks = 0, failures = 0;
  typedef struct packed {logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wd;} cmd_t;
  typedef struct packed {logic is_i; logic [31:0] data;} ret_t;
  cmd_t cq[$];
  ret_t rq[$];
  cmd_t c;
  ret_t r;

  always #5 clk = ~clk;

  avalon_mm_arbiter dut (
    .clk(clk), .rst(rst),
    .d_address(d_address), .d_byteenable(d_byteenable), .d_read(d_read), .d_write(d_write),
    .d_host_to_agent(d_host_to_agent), .d_waitrequest(d_waitrequest),
    .d_agent_to_host(d_agent_to_host), .d_readdatavalid(d_readdatavalid),
    .i_address(i_address), .i_byteenable(i_byteenable), .i_read(i_read),
    .i_waitrequest(i_waitrequest), .i_agent_to_host(i_agent_to_host), .i_readdatavalid(i_readdatavalid),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read), .a_write(a_write),
    .a_host_to_agent(a_host_to_agent), .a_waitrequest(a_waitrequest),
    .a_agent_to_host(a_agent_to_host), .a_readdatavalid(a_readdatavalid)
  );

  function automatic void chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endfunction

  function automatic void rd_d(input logic [31:0] a); cq.push_back({1'b0, a, 4'h3, 32'h0}); endfunction
  function automatic void rd_i(input logic [31:0] a); cq.push_back({1'b0, a, 4'hF, 32'h0}); endfunction
  function automatic void ret(input logic is_i, input logic [31:0] d); rq.push_back({is_i, d}); endfunction

  task automatic step(input logic dr, dw, input logic [31:0] da, dwd, input logic ir,
                      input logic [31:0] ia, input logic aw, rv, input logic [31:0] rd);
    @(posedge clk); #1;
    d_read = dr; d_write = dw; d_address = da; d_host_to_agent = dwd;
    i_read = ir; i_address = ia; a_waitrequest = aw; a_readdatavalid = rv; a_agent_to_host = rd;
    @(negedge clk);
  endtask
  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic beat(input logic [31:0] d); step(0, 0, 0, 0, 0, 0, 0, 1, d); endtask

  always @(negedge clk) if (rst) begin
    if ((a_read | a_write) && !a_waitrequest) begin
      if (cq.size() == 0) chk("cmd_unexpected", a_address, 32'hxxxx_xxxx);
      else begin
        c = cq.pop_front();
        chk("cmd_write", a_write, c.wr);
        chk("cmd_read", a_read, !c.wr);
        chk("cmd_addr", a_address, c.addr);
        chk("cmd_be", a_byteenable, c.be);
        if (c.wr) chk("cmd_wdata", a_host_to_agent, c.wd);
      end
    end
    if (d_readdatavalid || i_readdatavalid) begin
      if (rq.size() == 0) chk("ret_unexpected", {d_readdatavalid, i_readdatavalid}, 0);
      else begin
        r = rq.pop_front();
        chk("ret_both", d_readdatavalid & i_readdatavalid, 0);
        chk("ret_instr", i_readdatavalid, r.is_i);
        chk("ret_data", i_readdatavalid ? i_agent_to_host : d_agent_to_host, r.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0; d_byteenable = 4'h3; i_byteenable = 4'hF;
    d_read = 1; d_write = 0; d_address = 32'h200; d_host_to_agent = 0;
    i_read = 1; i_address = 0; a_waitrequest = 0; a_readdatavalid = 1; a_agent_to_host = 32'h1234;
    repeat (2) @(negedge clk);
    chk("rst_a_read", a_read, 0);
    chk("rst_a_write", a_write, 0);
    chk("rst_a_addr", a_address, 0);
    chk("rst_a_be", a_byteenable, 0);
    chk("rst_a_wdata", a_host_to_agent, 0);
    chk("rst_d_wait", d_waitrequest, 1);
    chk("rst_i_wait", i_waitrequest, 1);
    chk("rst_rdv", {d_readdatavalid, i_readdatavalid}, 0);
    chk("rst_rdata", d_agent_to_host | i_agent_to_host, 0);
    // Tie straight after reset: data first, then instruction.
    rd_d(32'h200); rd_i(32'h0); ret(0, 32'hD0); ret(1, 32'h10);
    @(posedge clk); #1 rst = 1; a_readdatavalid = 0;
    @(negedge clk);
    chk("tie_d_wait", d_waitrequest, 0);
    chk("tie_i_wait", i_waitrequest, 1);
    step(0, 0, 0, 0, 1, 32'h0, 0, 0, 0);
    chk("tie_i_second", i_waitrequest, 0);
    beat(32'hD0); beat(32'h10);
    // Both hosts keep requesting: fixed priority starves instr, round-robin alternates.
`ifdef AVALON_ARB_ROUND_ROBIN_EN
    rd_d(32'h300); rd_i(32'h4); rd_i(32'h4); ret(0, 32'h21); ret(1, 32'h22); ret(1, 32'h23);
`else
    rd_d(32'h300); rd_d(32'h300); rd_i(32'h4); ret(0, 32'h21); ret(0, 32'h22); ret(1, 32'h23);
`endif
    repeat (2) step(1, 0, 32'h300, 0, 1, 32'h4, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h4, 0, 0, 0);
    beat(32'h21); beat(32'h22); beat(32'h23);
    // Lone data read and its return.
    rd_d(32'h100); ret(0, 32'hDEADBEEF);
    step(1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("solo_a_read", a_read, 1);
    chk("solo_a_addr", a_address, 32'h100);
    idle();
    chk("idle_hold_addr", a_address, 32'h100);
    chk("idle_a_read", a_read, 0);
    beat(32'hDEADBEEF);
    chk("solo_d_rdv", d_readdatavalid, 1);
    chk("solo_i_rdv", i_readdatavalid, 0);
    // Interleaved reads D,I,D,I then beats 1..4.
    rd_d(32'h40); rd_i(32'h44); rd_d(32'h48); rd_i(32'h4C);
    ret(0, 1); ret(1, 2); ret(0, 3); ret(1, 4);
    step(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h44, 0, 0, 0);
    step(1, 0, 32'h48, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h4C, 0, 0, 0);
    for (int k = 1; k <= 4; k++) beat(k);
    // Data write stalled 3 cycles while instruction waits.
    cq.push_back({1'b1, 32'h400, 4'h3, 32'hCAFE}); rd_i(32'h8); ret(1, 32'h88);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 32'h400, 32'hCAFE, 1, 32'h8, k < 3, 0, 0);
      chk("lock_a_write", a_write, 1);
      chk("lock_a_addr", a_address, 32'h400);
      chk("lock_i_wait", i_waitrequest, 1);
      chk("lock_d_wait", d_waitrequest, k < 3);
    end
    step(0, 0, 0, 0, 1, 32'h8, 0, 0, 0);
    chk("lock_i_grant", a_read, 1);
    chk("lock_i_wait0", i_waitrequest, 0);
    beat(32'h88);
    // Fill the pending FIFO, then probe blocking, write bypass and same-cycle pop.
    for (int k = 0; k < 4; k++) begin
      rd_d(32'h10 + 4 * k); ret(0, 32'hA1 + k);
      step(1, 0, 32'h10 + 4 * k, 0, 0, 0, 0, 0, 0);
    end
    step(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    chk("full_d_wait", d_waitrequest, 1);
    chk("full_a_read", a_read, 0);
    cq.push_back({1'b1, 32'h500, 4'h3, 32'h55});
    step(0, 1, 32'h500, 32'h55, 0, 0, 0, 0, 0);
    chk("full_wr_wait", d_waitrequest, 0);
    chk("full_wr_go", a_write, 1);
    rd_i(32'hC); ret(1, 32'hB1);
    step(0, 0, 0, 0, 1, 32'hC, 0, 1, 32'hA1);
    chk("full_pop_i_wait", i_waitrequest, 0);
    chk("full_pop_a_read", a_read, 1);
    beat(32'hA2); beat(32'hA3); beat(32'hA4); beat(32'hB1);
    // Reset with two reads pending discards them.
    rd_d(32'h30); rd_i(32'h34);
    step(1, 0, 32'h30, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h34, 0, 0, 0);
    @(posedge clk); #1 rst = 0; i_read = 0;
    @(negedge clk);
    chk("mid_rst_d_wait", d_waitrequest, 1);
    chk("mid_rst_i_wait", i_waitrequest, 1);
    @(posedge clk); #1 rst = 1;
    beat(32'h99);
    chk("stray_rdv", {d_readdatavalid, i_readdatavalid}, 0);
    for (int k = 0; k < 4; k++) begin
      rd_d(32'h60 + 4 * k); ret(0, 32'h61 + k);
      step(1, 0, 32'h60 + 4 * k, 0, 0, 0, 0, 0, 0);
      chk("post_rst_wait", d_waitrequest, 0);
    end
    for (int k = 0; k < 4; k++) beat(32'h61 + k);
    repeat (3) idle();
    chk("cmd_queue_left", cq.size(), 0);
    chk("ret_queue_left", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
